// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        CALCULO  = 2'd1,
        FIN      = 2'd2
    } estado_div_t;

    localparam int ANCHO_DEFECTO = 32;

    // The counter must hold the value n itself, hence n+1 codes.
    function automatic int ancho_contador(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/divisor_secuencial_paso_division.sv
// One combinational restoring-division step, built on the team subtractor (resta).
// resta: a - b as a + ~b + 1; acarreo = 1 means no borrow (a >= b).
module resta #(
    parameter int ancho = 8
) (
    input  logic [ancho-1:0] a,
    input  logic [ancho-1:0] b,
    output logic [ancho-1:0] dif,
    output logic             acarreo
);

    assign {acarreo, dif} = {1'b0, a} + {1'b0, ~b} + {{ancho{1'b0}}, 1'b1};

endmodule

module paso_division #(
    parameter int n = 32
) (
    input  logic [n:0]   r,
    input  logic         q_msb,
    input  logic [n-1:0] d,
    output logic [n:0]   r_sig,
    output logic         bit_q
);

    logic [n:0] r_desp;
    logic [n:0] prueba;
    logic       acarreo;

    // R[n] is always zero after a restore, so it drops out of the shift.
    logic unused_r_msb;
    assign unused_r_msb = r[n];

    assign r_desp = {r[n-1:0], q_msb};

    resta #(
        .ancho(n + 1)
    ) u_resta (
        .a       (r_desp),
        .b       ({1'b0, d}),
        .dif     (prueba),
        .acarreo (acarreo)
    );

    assign bit_q = acarreo;
    assign r_sig = acarreo ? prueba : r_desp;

endmodule

// File: rtl/divisor_secuencial.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Define DIVISION_CON_SIGNO_EN for two's-complement operands and the overflow flag.
module divisor_secuencial
    import div_pkg::*;
#(
    parameter int n = ANCHO_DEFECTO
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inicio,
    input  logic [n-1:0] dividendo,
    input  logic [n-1:0] divisor,
    output logic         ocupado,
    output logic         listo,
    output logic [n-1:0] cociente,
    output logic [n-1:0] residuo,
    output logic         div_cero,
    output logic         desbordamiento
);

    localparam int CW = ancho_contador(n);

    estado_div_t    estado;
    estado_div_t    estado_sig;

    logic [n:0]     r_reg;
    logic [n-1:0]   q_reg;
    logic [n-1:0]   d_reg;
    logic [CW-1:0]  contador;

    logic [n:0]     r_sig;
    logic           bit_q;
    logic [n-1:0]   q_fin;
    logic [n-1:0]   r_fin;
    logic [n-1:0]   mag_dividendo;
    logic [n-1:0]   mag_divisor;
    logic           ultimo_paso;

    paso_division #(
        .n(n)
    ) u_paso (
        .r     (r_reg),
        .q_msb (q_reg[n-1]),
        .d     (d_reg),
        .r_sig (r_sig),
        .bit_q (bit_q)
    );

    assign q_fin       = {q_reg[n-2:0], bit_q};
    assign r_fin       = r_sig[n-1:0];
    assign ultimo_paso = (contador == CW'(1));

`ifdef DIVISION_CON_SIGNO_EN
    logic signo_q;
    logic signo_r;
    logic desb_pend;
    logic es_desborde;

    // The core always divides magnitudes; signs are reapplied on the last step.
    assign mag_dividendo = dividendo[n-1] ? -dividendo : dividendo;
    assign mag_divisor   = divisor[n-1]   ? -divisor   : divisor;
    assign es_desborde   = (dividendo == {1'b1, {(n-1){1'b0}}}) && (divisor == '1);
`else
    assign mag_dividendo  = dividendo;
    assign mag_divisor    = divisor;
    assign desbordamiento = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= INACTIVO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            INACTIVO: begin
                if (inicio) begin
                    estado_sig = (divisor == '0) ? FIN : CALCULO;
                end
            end
            CALCULO: begin
                if (ultimo_paso) begin
                    estado_sig = FIN;
                end
            end
            FIN:     estado_sig = INACTIVO;
            default: estado_sig = INACTIVO;
        endcase
    end

    always_comb begin
        ocupado = 1'b0;
        listo   = 1'b0;
        case (estado)
            CALCULO: ocupado = 1'b1;
            FIN:     listo   = 1'b1;
            default: ;
        endcase
    end

    // Results are only written on acceptance of a zero divisor or on the last step,
    // so they stay stable across FIN and the following idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg          <= '0;
            q_reg          <= '0;
            d_reg          <= '0;
            contador       <= '0;
            cociente       <= '0;
            residuo        <= '0;
            div_cero       <= 1'b0;
`ifdef DIVISION_CON_SIGNO_EN
            signo_q        <= 1'b0;
            signo_r        <= 1'b0;
            desb_pend      <= 1'b0;
            desbordamiento <= 1'b0;
`endif
        end else begin
            case (estado)
                INACTIVO: begin
                    if (inicio) begin
                        div_cero <= 1'b0;
`ifdef DIVISION_CON_SIGNO_EN
                        desbordamiento <= 1'b0;
                        signo_q        <= dividendo[n-1] ^ divisor[n-1];
                        signo_r        <= dividendo[n-1];
                        desb_pend      <= es_desborde;
`endif
                        if (divisor == '0) begin
                            cociente <= '1;
                            residuo  <= dividendo;
                            div_cero <= 1'b1;
                        end else begin
                            r_reg    <= '0;
                            q_reg    <= mag_dividendo;
                            d_reg    <= mag_divisor;
                            contador <= CW'(n);
                        end
                    end
                end
                CALCULO: begin
                    r_reg    <= r_sig;
                    q_reg    <= q_fin;
                    contador <= contador - CW'(1);
                    if (ultimo_paso) begin
`ifdef DIVISION_CON_SIGNO_EN
                        cociente       <= signo_q ? -q_fin : q_fin;
                        residuo        <= signo_r ? -r_fin : r_fin;
                        desbordamiento <= desb_pend;
`else
                        cociente <= q_fin;
                        residuo  <= r_fin;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Scoreboard bench for divisor_secuencial: directed cases plus random operands.
module tb_divisor_secuencial;

    localparam int N = 32;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ov;
        int           aceptado;
    } esperado_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         inicio;
    logic [N-1:0] dividendo;
    logic [N-1:0] divisor;
    logic         ocupado;
    logic         listo;
    logic [N-1:0] cociente;
    logic [N-1:0] residuo;
    logic         div_cero;
    logic         desbordamiento;

    esperado_t sb[$];
    int        cyc = 0;
    int        total = 0;
    int        pasados = 0;

    divisor_secuencial #(
        .n(N)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inicio         (inicio),
        .dividendo      (dividendo),
        .divisor        (divisor),
        .ocupado        (ocupado),
        .listo          (listo),
        .cociente       (cociente),
        .residuo        (residuo),
        .div_cero       (div_cero),
        .desbordamiento (desbordamiento)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string nombre, input logic [N-1:0] actual,
                               input logic [N-1:0] requerido);
        total++;
        if (actual === requerido) begin
            pasados++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", nombre, actual, requerido, $time);
        end
    endtask

    // Reference results from plain arithmetic on the operands.
    function automatic esperado_t modelo(input logic [N-1:0] a, input logic [N-1:0] b);
        esperado_t e;
        e.ov = 1'b0;
        e.dz = 1'b0;
        e.aceptado = 0;
        if (b == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
`ifdef DIVISION_CON_SIGNO_EN
            int sa;
            int sd;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q  = 32'h8000_0000;
                e.r  = '0;
                e.ov = 1'b1;
            end else begin
                sa  = a;
                sd  = b;
                e.q = 32'(sa / sd);
                e.r = 32'(sa % sd);
            end
`else
            e.q = a / b;
            e.r = a % b;
`endif
        end
        return e;
    endfunction

    // Called at a negedge; the following posedge is the accepting edge.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        esperado_t e;
        dividendo = a;
        divisor   = b;
        inicio    = 1'b1;
        @(posedge clk);
        #1;
        e = modelo(a, b);
        e.aceptado = cyc;
        sb.push_back(e);
        @(negedge clk);
        inicio    = 1'b0;
        dividendo = $urandom;
        divisor   = $urandom;
    endtask

    task automatic esperarListo();
        for (int i = 0; i < 100; i++) begin
            if (listo === 1'b1) return;
            @(negedge clk);
        end
        total++;
        $display("[TB] FAIL listo_timeout: got no listo within 100 cycles, expected listo");
    endtask

    task automatic operacion(input logic [N-1:0] a, input logic [N-1:0] b);
        applyStimulus(a, b);
        esperarListo();
        @(negedge clk);
    endtask

    // Monitor: pops one expectation per listo pulse and checks timing and results.
    initial begin : monitor
        int        ocup_cnt;
        logic      prev_listo;
        esperado_t e;
        ocup_cnt   = 0;
        prev_listo = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                ocup_cnt   = 0;
                prev_listo = 1'b0;
            end else begin
                if (prev_listo) checkOutput("listo_pulse", {31'd0, listo}, '0);
                if (ocupado === 1'b1) ocup_cnt++;
                if (listo === 1'b1) begin
                    if (sb.size() == 0) begin
                        total++;
                        $display("[TB] FAIL unexpected_listo: got listo with empty scoreboard, expected none");
                    end else begin
                        e = sb.pop_front();
                        checkOutput("cociente", cociente, e.q);
                        checkOutput("residuo", residuo, e.r);
                        checkOutput("div_cero", {31'd0, div_cero}, {31'd0, e.dz});
                        checkOutput("desbordamiento", {31'd0, desbordamiento}, {31'd0, e.ov});
                        checkOutput("latencia", 32'(cyc - e.aceptado), e.dz ? 32'd0 : 32'(N));
                        checkOutput("ciclos_ocupado", 32'(ocup_cnt), e.dz ? 32'd0 : 32'(N));
                    end
                    ocup_cnt = 0;
                end
                prev_listo = listo;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : estimulo
        logic [N-1:0] a;
        logic [N-1:0] b;
        rst       = 1'b1;
        inicio    = 1'b0;
        dividendo = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_cociente", cociente, '0);
        checkOutput("reset_residuo", residuo, '0);
        checkOutput("reset_ocupado", {31'd0, ocupado}, '0);
        checkOutput("reset_listo", {31'd0, listo}, '0);
        checkOutput("reset_div_cero", {31'd0, div_cero}, '0);
        checkOutput("reset_desbordamiento", {31'd0, desbordamiento}, '0);
        rst = 1'b0;
        @(negedge clk);

        operacion(32'd100, 32'd7);
        operacion(32'h1234, 32'd0);
        operacion(32'hFFFF_FFFF, 32'd1);
        operacion(32'd5, 32'd9);
        operacion(32'd0, 32'd3);
        operacion(32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Second start during CALCULO must be ignored; then a back-to-back start.
        applyStimulus(32'd100, 32'd7);
        repeat (3) @(negedge clk);
        dividendo = 32'd50;
        divisor   = 32'd5;
        inicio    = 1'b1;
        repeat (5) @(negedge clk);
        inicio = 1'b0;
        esperarListo();
        @(negedge clk);
        operacion(32'd50, 32'd5);

        // Asynchronous reset in the middle of CALCULO.
        applyStimulus(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        checkOutput("abort_cociente", cociente, '0);
        checkOutput("abort_residuo", residuo, '0);
        checkOutput("abort_ocupado", {31'd0, ocupado}, '0);
        checkOutput("abort_listo", {31'd0, listo}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        operacion(32'd81, 32'd9);

`ifdef DIVISION_CON_SIGNO_EN
        operacion(-32'sd7, 32'd2);
        operacion(32'd7, -32'sd2);
        operacion(32'h8000_0000, 32'hFFFF_FFFF);
`else
        operacion(32'hFFFF_FFF9, 32'd2);
`endif

        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = '0;
                1, 2:    b = 32'($urandom_range(1, 15));
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            operacion(a, b);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_vacio", 32'(sb.size()), '0);
        $display("%0d/%0d checks passed", pasados, total);
        $finish;
    end

endmodule
